// File: rtl/dot_product_acc.sv
// Dot-product engine: registers 4-bit operand pairs into a 4x4 array multiplier,
// accumulates LEN products and presents the wrapped sum with an overflow flag.
module dot_product_acc #(
    parameter int LEN   = 8,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_a_q, op_a_d;
    logic [3:0]       op_b_q, op_b_d;
    logic             p_valid_q, p_valid_d;
    logic [7:0]       in_cnt_q, in_cnt_d;
    logic [7:0]       add_cnt_q, add_cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             last_add;
    logic [7:0]       product;
    logic [ACC_W-1:0] acc_sum;
    logic             carry;

    // Shift-and-add over the partial-product rows of the 4x4 array.
    function automatic logic [7:0] array_mult(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) p = p + ({4'b0000, x} << i);
        end
        return p;
    endfunction

    assign in_ready = rst_n && (state_q == ACCUM);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        in_cnt_d    = in_cnt_q;
        add_cnt_d   = add_cnt_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        accept   = in_valid && in_ready;
        product  = array_mult(op_a_q, op_b_q);
        {carry, acc_sum} = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, product};
        last_add = p_valid_q && (add_cnt_q == 8'(LEN - 1));

        p_valid_d = accept;
        if (accept) begin
            op_a_d   = a;
            op_b_d   = b;
            in_cnt_d = in_cnt_q + 8'd1;
        end

        if (p_valid_q) begin
            acc_d     = acc_sum;
            ovf_d     = ovf_q | carry;
            add_cnt_d = add_cnt_q + 8'd1;
        end

        // The final product goes straight to the result register; the accumulator restarts.
        if (last_add) begin
            out_sum_d   = acc_sum;
            out_ovf_d   = ovf_q | carry;
            out_valid_d = 1'b1;
            acc_d       = '0;
            ovf_d       = 1'b0;
            add_cnt_d   = '0;
        end

        case (state_q)
            ACCUM: if (accept && (in_cnt_q + 8'd1 == 8'(LEN))) state_d = DRAIN;
            DRAIN: if (last_add) state_d = HOLD;
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    state_d     = ACCUM;
                    in_cnt_d    = '0;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            op_a_q      <= '0;
            op_b_q      <= '0;
            p_valid_q   <= 1'b0;
            in_cnt_q    <= '0;
            add_cnt_q   <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            p_valid_q   <= p_valid_d;
            in_cnt_q    <= in_cnt_d;
            add_cnt_q   <= add_cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dot_product_acc.sv
// Self-checking bench for dot_product_acc: a default instance (LEN=8, ACC_W=12) and a
// narrow instance (LEN=2, ACC_W=8), both checked against an arithmetic dot-product model.
module tb_dot_product_acc;

    logic        clk;
    logic        rst_n;
    logic        in_valid_v  [2];
    logic        in_ready_v  [2];
    logic [3:0]  a_v         [2];
    logic [3:0]  b_v         [2];
    logic        out_valid_v [2];
    logic        out_ready_v [2];
    logic        out_ovf_v   [2];
    logic [11:0] out_sum0;
    logic [7:0]  out_sum1;
    logic [31:0] sum_w       [2];

    int checks = 0;
    int errors = 0;
    int vec_a[$];
    int vec_b[$];

    dot_product_acc #(.LEN(8), .ACC_W(12)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v[0]),
        .in_ready  (in_ready_v[0]),
        .a         (a_v[0]),
        .b         (b_v[0]),
        .out_valid (out_valid_v[0]),
        .out_ready (out_ready_v[0]),
        .out_sum   (out_sum0),
        .out_ovf   (out_ovf_v[0])
    );

    dot_product_acc #(.LEN(2), .ACC_W(8)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v[1]),
        .in_ready  (in_ready_v[1]),
        .a         (a_v[1]),
        .b         (b_v[1]),
        .out_valid (out_valid_v[1]),
        .out_ready (out_ready_v[1]),
        .out_sum   (out_sum1),
        .out_ovf   (out_ovf_v[1])
    );

    assign sum_w[0] = 32'(out_sum0);
    assign sum_w[1] = 32'(out_sum1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expd);
        end
    endtask

    task automatic load_const(input int av, input int bv, input int n);
        vec_a.delete();
        vec_b.delete();
        for (int i = 0; i < n; i++) begin
            vec_a.push_back(av);
            vec_b.push_back(bv);
        end
    endtask

    task automatic load_random(input int n);
        vec_a.delete();
        vec_b.delete();
        for (int i = 0; i < n; i++) begin
            vec_a.push_back(int'($urandom_range(15)));
            vec_b.push_back(int'($urandom_range(15)));
        end
    endtask

    // Sends the queued vector to instance d, then checks timing and result against the model:
    // result = sum of products mod 2^w; overflow iff the true sum reaches 2^w.
    task automatic run_vector(input int d, input int w, input int gap_pct, input int bp,
                              input string tag);
        int          total;
        logic [31:0] exp_sum;
        logic        exp_ovf;
        int          n;
        total = 0;
        foreach (vec_a[i]) total += vec_a[i] * vec_b[i];
        exp_sum = 32'(total % (1 << w));
        exp_ovf = (total >= (1 << w));

        out_ready_v[d] = (bp == 0);
        foreach (vec_a[i]) begin
            n = 0;
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct && n < 8) begin
                in_valid_v[d] = 1'b0;
                a_v[d] = 4'($urandom);
                b_v[d] = 4'($urandom);
                tick();
                n++;
            end
            in_valid_v[d] = 1'b1;
            a_v[d] = 4'(vec_a[i]);
            b_v[d] = 4'(vec_b[i]);
            n = 0;
            while (in_ready_v[d] !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check({tag, "_accept_ready"}, 32'(in_ready_v[d]), 32'd1);
            tick();
        end
        in_valid_v[d] = 1'b0;

        check({tag, "_drain_ready"}, 32'(in_ready_v[d]), 32'd0);
        check({tag, "_drain_valid"}, 32'(out_valid_v[d]), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid_v[d]), 32'd1);
        check({tag, "_sum"}, sum_w[d], exp_sum);
        check({tag, "_ovf"}, 32'(out_ovf_v[d]), 32'(exp_ovf));
        check({tag, "_hold_ready"}, 32'(in_ready_v[d]), 32'd0);

        for (int k = 0; k < bp; k++) begin
            in_valid_v[d] = 1'b1;
            a_v[d] = 4'd15;
            b_v[d] = 4'd15;
            tick();
            check({tag, "_bp_valid"}, 32'(out_valid_v[d]), 32'd1);
            check({tag, "_bp_sum"}, sum_w[d], exp_sum);
            check({tag, "_bp_ovf"}, 32'(out_ovf_v[d]), 32'(exp_ovf));
            check({tag, "_bp_ready"}, 32'(in_ready_v[d]), 32'd0);
        end
        in_valid_v[d]  = 1'b0;
        out_ready_v[d] = 1'b1;
        tick();
        check({tag, "_done_valid"}, 32'(out_valid_v[d]), 32'd0);
        check({tag, "_done_ready"}, 32'(in_ready_v[d]), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d]  = 1'b1;
            a_v[d]         = 4'd15;
            b_v[d]         = 4'd15;
            out_ready_v[d] = 1'b0;
        end

        // Reset held for 3 cycles with valid junk on the inputs.
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_in_ready", 32'(in_ready_v[0]), 32'd0);
            check("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
            check("rst_out_sum", sum_w[0], 32'd0);
            check("rst_out_ovf", 32'(out_ovf_v[0]), 32'd0);
            check("rst_out_valid1", 32'(out_valid_v[1]), 32'd0);
        end
        in_valid_v[0] = 1'b0;
        in_valid_v[1] = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready_v[0]), 32'd1);
        check("rel_in_ready1", 32'(in_ready_v[1]), 32'd1);

        // Full-scale vector, back to back, out_ready high throughout.
        load_const(15, 15, 8);
        run_vector(0, 12, 0, 0, "full");

        // a=1..8, b=2: gap-free and then with random gaps.
        vec_a.delete();
        vec_b.delete();
        for (int i = 1; i <= 8; i++) begin
            vec_a.push_back(i);
            vec_b.push_back(2);
        end
        run_vector(0, 12, 0, 0, "ramp");
        run_vector(0, 12, 40, 0, "ramp_gap");

        // Backpressure for 5 cycles, then the next vector.
        load_const(15, 15, 8);
        run_vector(0, 12, 0, 5, "bp");
        load_const(3, 3, 8);
        run_vector(0, 12, 0, 0, "after_bp");

        // Overflow on the narrow instance, then a small vector.
        load_const(15, 15, 2);
        run_vector(1, 8, 0, 0, "ovf");
        vec_a.delete();
        vec_b.delete();
        vec_a.push_back(1); vec_b.push_back(1);
        vec_a.push_back(0); vec_b.push_back(0);
        run_vector(1, 8, 0, 0, "ovf_next");

        // Reset after 4 of 8 pairs: nothing emitted, next vector clean.
        in_valid_v[0] = 1'b1;
        a_v[0] = 4'd15;
        b_v[0] = 4'd15;
        for (int k = 0; k < 4; k++) tick();
        in_valid_v[0] = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("abort_out_valid", 32'(out_valid_v[0]), 32'd0);
            check("abort_in_ready", 32'(in_ready_v[0]), 32'd1);
        end
        load_const(2, 3, 8);
        run_vector(0, 12, 0, 0, "post_abort");

        // Random vectors on both instances with random gaps and backpressure.
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                load_random(8);
                run_vector(0, 12, 30, int'($urandom_range(3)), "rand0");
            end else begin
                load_random(2);
                run_vector(1, 8, 30, int'($urandom_range(3)), "rand1");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_product_acc.md
# dot_product_acc

Sequential multiply-accumulate stage directly downstream of the 4x4 unsigned array multiplier. It accepts a stream of 4-bit operand pairs over a valid/ready handshake and registers each pair into the multiplier inputs. It accumulates the 8-bit products over a fixed vector length and presents the wrapped sum with an overflow flag on an output valid/ready handshake. It is the first clocked block around the combinational multiplier datapath and turns it into a dot-product engine.

## Interface
- LEN, 8: pairs per vector; legal range 1..255.
- ACC_W, 12: accumulator and result width; legal range 8..16. The default holds 8 x 225 = 1800 without overflow.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block accepts a pair this cycle.
- a  input  4  unsigned multiplicand.
- b  input  4  unsigned multiplier.
- out_valid  output  1  out_sum/out_ovf hold a completed vector result.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  sum of LEN products, modulo 2^ACC_W.
- out_ovf  output  1  a carry out of bit ACC_W-1 occurred during this vector.

## Operation
- States:
  - ACCUM: accepting pairs.
  - DRAIN: all LEN pairs accepted, last product not yet added.
  - HOLD: result presented.
- Reset state is ACCUM.
- Input handshake:
  - A pair is accepted when in_valid && in_ready at a rising edge.
  - When in_ready=0, in_valid, a and b are ignored.
  - in_ready = rst_n && (state==ACCUM).
- Stage 1 (operand register):
  - On accept: op_a<=a, op_b<=b, p_valid<=1, in_cnt<=in_cnt+1.
  - Otherwise p_valid<=0.
  - op_a/op_b drive the combinational 4x4 multiplier; the product is 8 bits.
- Stage 2 (accumulate):
  - When p_valid: {carry, acc} <= acc + {0, product}, extended to ACC_W bits; ovf<=ovf|carry; add_cnt<=add_cnt+1.
- Last product (add_cnt==LEN-1 while p_valid):
  - out_sum <= acc + product, with the sum wrapped.
  - out_ovf <= ovf|carry.
  - out_valid<=1; acc, ovf, add_cnt <= 0; state<=HOLD.
- Transitions:
  - ACCUM->DRAIN when the accept brings in_cnt to LEN.
  - DRAIN->HOLD on the last add.
  - HOLD->ACCUM on out_valid && out_ready; at that edge in_cnt<=0 and out_valid<=0.
- LEN=1:
  - The single accept goes ACCUM->DRAIN.
  - The next edge performs the add and enters HOLD.
- Counters in_cnt and add_cnt are 8 bits. Neither counter exceeds LEN.
- While out_valid=1 and out_ready=0, out_sum and out_ovf stay stable.
- Reset (rst_n=0 at a rising edge), including mid-vector:
  - Clears to 0: state=ACCUM, op_a, op_b, p_valid, in_cnt, add_cnt, acc, ovf, out_sum, out_ovf, out_valid.
  - Any partial sum is discarded and no result is emitted.

## Timing
- Reset values: out_valid=0, out_sum=0, out_ovf=0. in_ready=0 while rst_n=0 and 1 in the first cycle after release.
- Throughput: one pair per cycle in ACCUM.
- Latency:
  - The last pair is accepted at edge t.
  - Its product is added at edge t+1, so out_valid=1 in the cycle after t+1.
- Per-vector overhead between the last accept of one vector and the first accept of the next:
  - 1 DRAIN cycle.
  - At least 1 HOLD cycle.
  - With out_ready held at 1, the next vector's first accept occurs at edge t+3.
- out_ready may be high before out_valid. Only the cycle with both high counts as the handshake.
- in_valid gaps are allowed anywhere in a vector and do not change the result.

## Test plan
- Reset:
  - Stimulus: rst_n=0 for 3 cycles with in_valid=1, a=15, b=15.
  - Required: in_ready=0, out_valid=0, out_sum=0, out_ovf=0; in_ready=1 in the first cycle after release.
- Full-scale vector (LEN=8, ACC_W=12):
  - Stimulus: 8 back-to-back pairs (15,15), out_ready=1.
  - Required: out_sum=1800, out_ovf=0; out_valid high exactly 1 cycle, first seen in the cycle after edge t+1; in_ready=0 from after edge t until HOLD exits.
- Gapped stream:
  - Stimulus: a=1..8, b=2, with random in_valid gaps.
  - Required: out_sum=72, out_ovf=0, identical to the gap-free run.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid, then 1.
  - Required: out_sum and out_ovf stable and in_ready=0 for all 5 cycles; the next vector (3,3)x8 yields 72.
- Overflow (ACC_W=8, LEN=2):
  - Stimulus: (15,15),(15,15); then a second vector (1,1),(0,0).
  - Required: first result out_sum=194 (450 mod 256), out_ovf=1; second result out_sum=1, out_ovf=0.
- Reset mid-vector:
  - Stimulus: after 4 of 8 pairs (15,15), pulse rst_n=0 for 1 cycle; then send (2,3)x8.
  - Required: no out_valid for the aborted vector; the new vector gives out_sum=48, out_ovf=0.
